fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register. Holds the PC and fetches one
//   32-bit word per request over a req/ack instruction-memory port (variable latency).
//   Presents instr/pc/valid to decode, where the immediate generator consumes them.
//   Supports decode back-pressure (id_ready) and PC redirect from branch/jump resolution.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC of the first fetch after reset
//   NOP_INSTR 32'h0000_0013  value driven on id_instr while id_valid=0 (addi x0,x0,0)
// PORTS
//   clk             in   1   clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   imem_req        out  1   fetch request; once high, held until imem_ack
//   imem_addr       out  32  word address (bits[1:0]=0); stable while imem_req=1
//   imem_ack        in   1   data valid; may assert in the same cycle as imem_req
//   imem_rdata      in   32  instruction word, sampled on the edge where req&&ack
//   redirect_valid  in   1   1-cycle pulse: flush and restart fetch at redirect_pc
//   redirect_pc     in   32  new PC; bits[1:0] ignored (forced 0)
//   id_ready        in   1   decode accepts id_* this cycle
//   id_valid        out  1   id_instr/id_pc hold a valid instruction
//   id_instr        out  32  fetched instruction (NOP_INSTR when id_valid=0)
//   id_pc           out  32  address of id_instr
//   id_imm_sel      out  1   registered: id_valid && id_instr[6:0]!=7'b0110011 (R-type)
// BEHAVIOUR
//   Reset (async assert, sync release): pc=RESET_PC, state=RUN, id_valid=0,
//     id_instr=NOP_INSTR, id_pc=0, id_imm_sel=0, imem_req=0 while rst_n=0.
//   imem_addr = pc. States: RUN (no request outstanding), WAIT (outstanding),
//     DISCARD (outstanding, data to be dropped).
//   RUN: imem_req = (!id_valid || id_ready) && !redirect_valid.
//     req&&ack -> load IF/ID regs, pc<=pc+4, stay RUN. req&&!ack -> WAIT.
//   WAIT: imem_req=1. ack -> load IF/ID, pc<=pc+4, ->RUN. IF/ID slot is always empty or
//     draining when ack arrives (only acks fill it), so no extra buffer exists.
//   IF/ID load: id_valid<=1, id_instr<=imem_rdata, id_pc<=pc, id_imm_sel per rule above.
//   Consume: id_valid && id_ready with no load -> id_valid<=0, id_instr<=NOP_INSTR.
//   Stall: id_valid && !id_ready -> id_* stable, no new request issued.
//   Redirect (highest priority, any state): id_valid<=0, id_instr<=NOP_INSTR,
//     pc<={redirect_pc[31:2],2'b00}; imem_req is not raised from RUN in that cycle.
//     In RUN -> RUN (first fetch of new PC issued next cycle).
//     In WAIT with ack same cycle -> data dropped, ->RUN.
//     In WAIT without ack -> DISCARD (req held, addr holds old pc until ack).
//   DISCARD: imem_req=1, imem_addr=old outstanding address (kept in a separate reg);
//     ack -> drop data, no IF/ID load, ->RUN. A further redirect updates pc, stays DISCARD.
//   PC wraps modulo 2^32 (0xFFFF_FFFC+4 = 0). Latency: ack on edge N -> id_valid at N+1.
//   Peak throughput 1 instr/cycle with same-cycle ack and id_ready=1.
// TESTING
//   Reset release, ack tied high, rdata 0x00500093,0x00A00113 -> req at addr 0x0 first
//     cycle; id_pc 0x0,0x4 on consecutive cycles, id_imm_sel=1, no bubbles.
//   2-cycle ack latency, id_ready=1 -> one instr per 3 cycles, imem_addr stable while waiting.
//   id_ready=0 for 4 cycles with id_valid=1 -> id_* unchanged, imem_req=0, no PC advance;
//     id_ready=1 -> fetch resumes at next PC.
//   R-type 0x002081B3 fetched -> id_imm_sel=0; sw 0x00112023 -> id_imm_sel=1.
//   Redirect to 0x100 while in WAIT, ack 2 cycles later with 0xDEADBEEF -> no id_valid for
//     that data; next req addr 0x100. Redirect+ack same cycle -> data dropped, next req 0x100.
//   Assert rst_n=0 mid-WAIT -> outputs at reset values immediately; after release first
//     req at RESET_PC; PC wrap 0xFFFF_FFFC -> next addr 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Keeps at most one req/ack fetch in flight and handles decode stalls and PC redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_imm_sel
);
  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] discAddr_q, discAddr_d;
  logic        idValid_q, idValid_d;
  logic [31:0] idInstr_q, idInstr_d;
  logic [31:0] idPc_q, idPc_d;
  logic        idImmSel_q, idImmSel_d;
  logic        fetchHs;
  logic        load;

  // A new fetch leaves RUN only when the IF/ID slot is free or draining this cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      ST_RUN:     imem_req = (!idValid_q || id_ready) && !redirect_valid;
      ST_WAIT:    imem_req = 1'b1;
      ST_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = discAddr_q;
      end
      default:    imem_req = 1'b0;
    endcase
    if (!rst_n) imem_req = 1'b0;
  end

  assign fetchHs = imem_req && imem_ack;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discAddr_d = discAddr_q;
    idValid_d  = idValid_q;
    idInstr_d  = idInstr_q;
    idPc_d     = idPc_q;
    idImmSel_d = idImmSel_q;
    load       = 1'b0;

    if (idValid_q && id_ready) begin
      idValid_d  = 1'b0;
      idInstr_d  = NOP_INSTR;
      idImmSel_d = 1'b0;
    end

    if (redirect_valid) begin
      idValid_d  = 1'b0;
      idInstr_d  = NOP_INSTR;
      idImmSel_d = 1'b0;
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      case (state_q)
        ST_RUN:  state_d = ST_RUN;
        ST_WAIT: begin
          // The in-flight fetch belongs to the old path; remember its address for the bus.
          if (imem_ack) begin
            state_d = ST_RUN;
          end else begin
            state_d    = ST_DISCARD;
            discAddr_d = pc_q;
          end
        end
        ST_DISCARD: if (imem_ack) state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fetchHs)       load    = 1'b1;
          else if (imem_req) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_ack) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_DISCARD: if (imem_ack) state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end

    if (load) begin
      idValid_d  = 1'b1;
      idInstr_d  = imem_rdata;
      idPc_d     = pc_q;
      idImmSel_d = (imem_rdata[6:0] != OPCODE_RTYPE);
      pc_d       = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      discAddr_q <= '0;
      idValid_q  <= 1'b0;
      idInstr_q  <= NOP_INSTR;
      idPc_q     <= '0;
      idImmSel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discAddr_q <= discAddr_d;
      idValid_q  <= idValid_d;
      idInstr_q  <= idInstr_d;
      idPc_q     <= idPc_d;
      idImmSel_q <= idImmSel_d;
    end
  end

  assign id_valid   = idValid_q;
  assign id_instr   = idInstr_q;
  assign id_pc      = idPc_q;
  assign id_imm_sel = idImmSel_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the fetch pipeline.
module tb_fetch_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [6:0]  RTYP = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_imm_sel;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_imm_sel(id_imm_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: next fetch PC, at most one outstanding request (possibly doomed), one decode slot.
  logic [31:0] mPc, mOutAddr, mSlotI, mSlotPc;
  bit          mOut, mDrop, mSlotV;
  logic [31:0] ovQ[$];
  int          reqAge, reqLat, minLat, maxLat;
  bit          curRedir, curReady, curAck, expReq;
  logic [31:0] curRpc, curRdata, expAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    if (a[3:2] == 2'd1) return {h[31:7], RTYP};
    return h;
  endfunction

  function automatic logic [98:0] expVec();
    return {expReq, expAddr, mSlotV, (mSlotV ? mSlotI : NOP), mSlotPc,
            (mSlotV && (mSlotI[6:0] != RTYP))};
  endfunction

  function automatic logic [98:0] obsVec();
    return {imem_req, imem_addr, id_valid, id_instr, id_pc, id_imm_sel};
  endfunction

  task automatic modelReset();
    mPc = 32'h0; mOut = 0; mDrop = 0; mOutAddr = '0;
    mSlotV = 0; mSlotI = NOP; mSlotPc = '0;
    reqAge = 0; reqLat = 0; ovQ.delete();
    expReq = 0; expAddr = mPc;
  endtask

  // ackSel: 0 never, 1 whenever requested, 2 after random latency, 3 tied high.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit ready,
                               input int ackSel);
    curRedir = redir; curRpc = rpc; curReady = ready;
    expReq  = rst_n && (mOut || ((!mSlotV || ready) && !redir));
    expAddr = mOut ? mOutAddr : mPc;
    if (expReq && reqAge == 0) reqLat = $urandom_range(maxLat, minLat);
    case (ackSel)
      0:       curAck = 1'b0;
      1:       curAck = expReq;
      3:       curAck = 1'b1;
      default: curAck = expReq && (reqAge >= reqLat);
    endcase
    curRdata = (ovQ.size() != 0) ? ovQ[0] : memWord(expAddr);
    redirect_valid = redir; redirect_pc = rpc; id_ready = ready;
    imem_ack = curAck; imem_rdata = curRdata;
    #1;
  endtask

  task automatic advance();
    bit hs;
    @(posedge clk);
    hs = expReq && curAck;
    if (curRedir) begin
      mSlotV = 0;
      mPc = {curRpc[31:2], 2'b00};
    end else if (hs && !mDrop) begin
      mSlotV = 1; mSlotI = curRdata; mSlotPc = mPc; mPc = mPc + 32'd4;
    end else if (mSlotV && curReady) begin
      mSlotV = 0;
    end
    if (hs) begin
      mOut = 0; mDrop = 0;
      if (ovQ.size() != 0) void'(ovQ.pop_front());
    end else if (expReq) begin
      if (!mOut) mOutAddr = expAddr;
      mOut = 1;
      if (curRedir) mDrop = 1;
    end
    reqAge = (expReq && !hs) ? reqAge + 1 : 0;
    @(negedge clk);
  endtask

  task automatic settle();
    for (int i = 0; i < 8 && mOut; i++) begin
      applyStimulus(0, 32'h0, 1, 1);
      advance();
    end
  endtask

  task automatic test_reset();
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", obsVec(), expVec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    ovQ.push_back(32'h0050_0093);
    ovQ.push_back(32'h00A0_0113);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 32'h0, 1, 3);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc%0d: got %h expected %h", i, obsVec(), expVec());
      end
      if (i == 0) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
          errors++;
          $display("[TB] FAIL first_req: got req=%0b addr=%h expected req=1 addr=0", imem_req, imem_addr);
        end
      end
      if (i == 1 || i == 2) begin
        checks++;
        if ({id_valid, id_pc, id_imm_sel} !== {1'b1, (i == 1) ? 32'h0 : 32'h4, 1'b1}) begin
          errors++;
          $display("[TB] FAIL b2b_slot cyc%0d: got v=%0b pc=%h imm=%0b", i, id_valid, id_pc, id_imm_sel);
        end
      end
      advance();
    end
  endtask

  task automatic test_imm_sel();
    ovQ.push_back(32'h0020_81B3);
    ovQ.push_back(32'h0011_2023);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 32'h0, 1, 1);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL imm_sel cyc%0d: got %h expected %h", i, obsVec(), expVec());
      end
      if (i == 1 || i == 2) begin
        checks++;
        if ({id_instr, id_imm_sel} !== ((i == 1) ? {32'h0020_81B3, 1'b0} : {32'h0011_2023, 1'b1})) begin
          errors++;
          $display("[TB] FAIL imm_sel_const cyc%0d: got instr=%h imm=%0b", i, id_instr, id_imm_sel);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [31:0] nextAddr;
    for (int i = 0; i < 8 && !(mSlotV && !mOut); i++) begin
      applyStimulus(0, 32'h0, 1, 1);
      advance();
    end
    nextAddr = mSlotPc + 32'd4;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 32'h0, 0, 1);
      checks++;
      if (obsVec() !== expVec() || imem_req !== 1'b0 || id_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall cyc%0d: got %h expected %h", i, obsVec(), expVec());
      end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h0, 1, 1);
      checks++;
      if (obsVec() !== expVec() || (i == 0 && imem_addr !== nextAddr)) begin
        errors++;
        $display("[TB] FAIL stall_resume cyc%0d: got %h expected %h", i, obsVec(), expVec());
      end
      advance();
    end
  endtask

  task automatic test_latency();
    minLat = 2; maxLat = 2;
    settle();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 32'h0, 1, 2);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL latency cyc%0d: got %h expected %h", i, obsVec(), expVec());
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    // Steps: issue, redirect while waiting, wait, ack junk, reissue, redirect+ack, reissue.
    bit          rd[7]  = '{0, 1, 0, 0, 0, 1, 0};
    int          ak[7]  = '{0, 0, 0, 1, 0, 1, 1};
    logic [31:0] rp[7]  = '{0, 32'h100, 0, 0, 0, 32'h103, 0};
    settle();
    ovQ.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) ovQ.push_back(32'hDEAD_BEEF);
      applyStimulus(rd[i], rp[i], 1, ak[i]);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL redirect cyc%0d: got %h expected %h", i, obsVec(), expVec());
      end
      if (i == 4 || i == 6) begin
        checks++;
        if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
          errors++;
          $display("[TB] FAIL redirect_target cyc%0d: got v=%0b req=%0b addr=%h", i, id_valid, imem_req, imem_addr);
        end
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    settle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 0, 32'hFFFF_FFFF, 1, (i == 0) ? 0 : 1);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL wrap cyc%0d: got %h expected %h", i, obsVec(), expVec());
      end
      if (i == 2) begin
        checks++;
        if ({imem_req, imem_addr, id_pc} !== {1'b1, 32'h0, 32'hFFFF_FFFC}) begin
          errors++;
          $display("[TB] FAIL wrap_addr: got req=%0b addr=%h id_pc=%h", imem_req, imem_addr, id_pc);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    minLat = 0; maxLat = 3;
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, $urandom(), $urandom_range(0, 3) != 0, 2);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL random cyc%0d: got %h expected %h", i, obsVec(), expVec());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_wait();
    settle();
    applyStimulus(0, 32'h0, 1, 0);
    advance();
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checks++;
    if (obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_mid_wait: got %h expected %h", obsVec(), expVec());
    end
    redirect_valid = 0; imem_ack = 0; id_ready = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 32'h0, 1, 1);
    checks++;
    if (obsVec() !== expVec() || {imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_release_req: got %h expected %h", obsVec(), expVec());
    end
    advance();
  endtask

  initial begin
    minLat = 0; maxLat = 0;
    test_reset();
    test_back_to_back();
    test_imm_sel();
    test_stall();
    test_latency();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
